// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and parity-mode constants for the word UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period timer; tick marks the last cycle of each CLK_DIV-cycle bit
module uart_baud_tick #(
  parameter int CLK_DIV = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - serialises a BYTES-wide word as back-to-back UART characters, top lane first
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int BYTES     = 3,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      BYTES < 1 || BYTES > 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
      (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN)) begin : g_bad_params
    $error("uart_word_tx: illegal parameter value");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [1:0] TOP_LANE  = 2'(BYTES - 1);
  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  state_e      state_q, state_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic        restart;
  logic        tick;
  logic [7:0]  cur_byte;
  logic        par_bit;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // Word is zero-extended to 32 bits so every lane select stays in range.
  assign cur_byte = word_q[{byte_q, 3'b000} +: 8];
  assign par_bit  = (PARITY == PAR_ODD) ? ~(^(cur_byte & DATA_MASK)) : ^(cur_byte & DATA_MASK);

  // tx_d is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (in_valid && in_ready) begin
          word_d  = 32'(in_data);
          byte_d  = TOP_LANE;
          bit_d   = '0;
          restart = 1'b1;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q != LAST_DATA) begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end else if (PARITY != PAR_NONE) begin
            tx_d    = par_bit;
            state_d = ST_PARITY;
          end else begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q != LAST_STOP) begin
            bit_d = bit_q + 3'd1;
          end else if (byte_q != 2'd0) begin
            byte_d  = byte_q - 2'd1;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            done_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed and randomised checks of uart_word_tx across five parameter sets
module tb_uart_word_tx;

  logic        clk;
  logic        reset;
  logic [4:0]  valid_v;
  logic [4:0]  ready_v;
  logic [4:0]  tx_v;
  logic [4:0]  busy_v;
  logic [4:0]  done_v;
  logic [31:0] din [5];

  int cdiv_a  [5] = '{4, 4, 4, 2, 2};
  int bytes_a [5] = '{3, 1, 1, 2, 4};
  int dbits_a [5] = '{8, 7, 8, 6, 8};
  int par_a   [5] = '{0, 2, 1, 1, 2};
  int stop_a  [5] = '{1, 1, 2, 1, 2};

  int n_checks;
  int n_fail;
  bit line_q[$];

  typedef struct {
    int              k;
    logic [31:0]     data;
    logic [3:0][7:0] exp;
    int              len;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx #(.CLK_DIV(4), .DATA_BITS(8), .BYTES(3), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
    .in_data(din[0][23:0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_word_tx #(.CLK_DIV(4), .DATA_BITS(7), .BYTES(1), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
    .in_data(din[1][7:0]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_word_tx #(.CLK_DIV(4), .DATA_BITS(8), .BYTES(1), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(valid_v[2]), .in_ready(ready_v[2]),
    .in_data(din[2][7:0]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_word_tx #(.CLK_DIV(2), .DATA_BITS(6), .BYTES(2), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .in_valid(valid_v[3]), .in_ready(ready_v[3]),
    .in_data(din[3][15:0]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_word_tx #(.CLK_DIV(2), .DATA_BITS(8), .BYTES(4), .PARITY(2), .STOP_BITS(2)) u4 (
    .clk(clk), .reset(reset), .in_valid(valid_v[4]), .in_ready(ready_v[4]),
    .in_data(din[4]), .tx(tx_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input logic [31:0] d, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input int len);
    vec_t v;
    v.k    = k;
    v.data = d;
    v.exp  = {8'h00, e2, e1, e0};
    v.len  = len;
    return v;
  endfunction

  function automatic bit ln(input int i);
    return (i < line_q.size()) ? line_q[i] : 1'b0;
  endfunction

  // Called on a negedge while idle; returns on the first low-tx cycle.
  task automatic offer(input int k, input logic [31:0] d);
    int w;
    w = 0;
    din[k]     = d;
    valid_v[k] = 1'b1;
    while (!ready_v[k] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    valid_v[k] = 1'b0;
    chk("start_latency", tx_v[k], 0);
  endtask

  // Reference receiver: records the line every cycle until done, then checks
  // every bit is a flat CLK_DIV-cycle level with correct framing and parity.
  task automatic run_frame(input int k, input logic [3:0][7:0] exp, input int exp_len);
    int n, errs, f, d, idx;
    bit busy_ok, v, pe;
    logic [7:0] ch;
    n = 0;
    busy_ok = 1'b1;
    line_q.delete();
    while (!done_v[k] && n < 2000) begin
      line_q.push_back(tx_v[k]);
      if (!busy_v[k]) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("frame_len", line_q.size(), exp_len);
    chk("busy_in_frame", busy_ok, 1);
    d = cdiv_a[k];
    f = 1 + dbits_a[k] + ((par_a[k] != 0) ? 1 : 0) + stop_a[k];
    errs = 0;
    for (int c = 0; c < bytes_a[k]; c++) begin
      ch = '0;
      for (int p = 0; p < f; p++) begin
        idx = (c * f + p) * d;
        v = ln(idx);
        for (int s = 1; s < d; s++) if (ln(idx + s) != v) errs++;
        if (p == 0) begin
          if (v != 1'b0) errs++;
        end else if (p <= dbits_a[k]) begin
          ch[p-1] = v;
        end else if (par_a[k] != 0 && p == dbits_a[k] + 1) begin
          pe = ^ch;
          if (par_a[k] == 1) pe = ~pe;
          if (v != pe) errs++;
        end else if (v != 1'b1) begin
          errs++;
        end
      end
      chk($sformatf("char%0d_k%0d", c, k), ch, exp[c]);
    end
    chk("framing_errors", errs, 0);
    chk("done_cycle_ready_tx", {ready_v[k], tx_v[k], done_v[k]}, 3'b111);
  endtask

  task automatic after_done(input int k);
    @(negedge clk);
    chk("done_width", done_v[k], 0);
    chk("idle_tx_high", tx_v[k], 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] e;
    logic [31:0] d;
    int cnt, len;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    valid_v  = '0;
    for (int i = 0; i < 5; i++) din[i] = '0;

    vecs[0] = mk(0, 32'h00A53C01, 8'hA5, 8'h3C, 8'h01, 120);
    vecs[1] = mk(1, 32'h000000FF, 8'h7F, 8'h00, 8'h00, 40);
    vecs[2] = mk(2, 32'h00000000, 8'h00, 8'h00, 8'h00, 48);
    vecs[3] = mk(0, 32'h00FF0080, 8'hFF, 8'h00, 8'h80, 120);
    vecs[4] = mk(1, 32'h0000002A, 8'h2A, 8'h00, 8'h00, 40);
    vecs[5] = mk(2, 32'h00000081, 8'h81, 8'h00, 8'h00, 48);

    repeat (3) @(negedge clk);
    chk("reset_tx", tx_v, 5'h1f);
    chk("reset_busy", busy_v, 5'h00);
    chk("reset_done", done_v, 5'h00);
    chk("reset_ready", ready_v, 5'h00);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", ready_v, 5'h1f);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].k, vecs[i].data);
      run_frame(vecs[i].k, vecs[i].exp, vecs[i].len);
      after_done(vecs[i].k);
    end

    // in_valid held across the whole frame: new data mid-frame is ignored,
    // and the second word is taken on the done cycle.
    din[0]     = 32'h00112233;
    valid_v[0] = 1'b1;
    @(negedge clk);
    chk("b2b_first_start", tx_v[0], 0);
    din[0] = 32'h00C0FFEE;
    run_frame(0, {8'h00, 8'h33, 8'h22, 8'h11}, 120);
    @(negedge clk);
    chk("b2b_second_start", tx_v[0], 0);
    valid_v[0] = 1'b0;
    run_frame(0, {8'h00, 8'hEE, 8'hFF, 8'hC0}, 120);
    after_done(0);

    // Abort during the data bits of the second character.
    offer(0, 32'h00123456);
    repeat (50) @(negedge clk);
    chk("busy_before_abort", busy_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {tx_v[0], busy_v[0], done_v[0], ready_v[0]}, 4'b1000);
    reset = 1'b0;
    #1;
    chk("abort_ready", ready_v[0], 1);
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done_v[0] || !tx_v[0]) cnt++;
    end
    chk("abort_no_done_no_tx", cnt, 0);
    offer(0, 32'h005AC3E7);
    run_frame(0, {8'h00, 8'hE7, 8'hC3, 8'h5A}, 120);
    after_done(0);

    for (int k = 3; k < 5; k++) begin
      for (int r = 0; r < 6; r++) begin
        d = $urandom;
        e = '0;
        for (int c = 0; c < bytes_a[k]; c++)
          e[c] = d[8*(bytes_a[k]-1-c) +: 8] & (8'hFF >> (8 - dbits_a[k]));
        len = bytes_a[k] * cdiv_a[k] *
              (1 + dbits_a[k] + ((par_a[k] != 0) ? 1 : 0) + stop_a[k]);
        offer(k, d);
        run_frame(k, e, len);
        after_done(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
